// File: rtl/bcd_digit_serializer.sv
// Captures a packed DIGIT-digit BCD word and emits it MSD first, one nibble per beat,
// tagging the LSD and flagging nibbles > 9. Define BCD_LZS_EN for leading-zero suppression.
module bcd_digit_serializer #(
  parameter int unsigned DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIGIT*4-1:0] in_bcd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_digit,
  output logic               out_last,
  output logic               out_err
);

  localparam int unsigned W  = DIGIT * 4;
  localparam int unsigned IW = (DIGIT > 1) ? $clog2(DIGIT) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  word_q, word_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [IW-1:0] start_idx;
  logic [3:0]    digit_nxt, first_nib, next_nib;
  logic          last_nxt, err_nxt;

  // Select nibble i of a word without a variable-width part-select.
  function automatic logic [3:0] nibble(input logic [W-1:0] w, input logic [IW-1:0] i);
    nibble = 4'd0;
    for (int unsigned k = 0; k < DIGIT; k++) begin
      if (IW'(k) == i) nibble = w[4*k +: 4];
    end
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      word_q    <= '0;
      idx       <= '0;
      out_digit <= 4'd0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      word_q    <= word_nxt;
      idx       <= idx_nxt;
      out_digit <= digit_nxt;
      out_last  <= last_nxt;
      out_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    word_nxt  = word_q;
    idx_nxt   = idx;
    digit_nxt = out_digit;
    last_nxt  = out_last;
    err_nxt   = out_err;

`ifdef BCD_LZS_EN
    // Highest non-zero nibble starts the word; an all-zero word emits only the LSD.
    start_idx = '0;
    for (int unsigned k = 0; k < DIGIT; k++) begin
      if (in_bcd[4*k +: 4] != 4'd0) start_idx = IW'(k);
    end
`else
    start_idx = IW'(DIGIT - 1);
`endif

    first_nib = nibble(in_bcd, start_idx);
    next_nib  = nibble(word_q, idx - IW'(1));

    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = SEND;
          word_nxt  = in_bcd;
          idx_nxt   = start_idx;
          digit_nxt = first_nib;
          last_nxt  = (start_idx == '0);
          err_nxt   = (first_nib > 4'd9);
        end
      end
      SEND: begin
        if (out_ready) begin
          if (out_last) begin
            state_nxt = IDLE;
            digit_nxt = 4'd0;
            last_nxt  = 1'b0;
            err_nxt   = 1'b0;
          end else begin
            idx_nxt   = idx - IW'(1);
            digit_nxt = next_nib;
            last_nxt  = (idx_nxt == '0);
            err_nxt   = (next_nib > 4'd9);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bcd_digit_serializer.sv
// Self-checking bench for bcd_digit_serializer: directed vector table, hand sequences
// for back-pressure and mid-word reset, and a randomized run against a digit-queue model.
module tb_bcd_digit_serializer;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_last4, out_err4;
  logic [15:0] in_bcd4;
  logic [3:0]  out_digit4;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_last2, out_err2;
  logic [7:0]  in_bcd2;
  logic [3:0]  out_digit2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] word;
    int          nbeats;
    logic [15:0] digits;  // beat i lives in nibble nbeats-1-i
    logic [3:0]  errs;    // beat i lives in bit nbeats-1-i
  } vec_t;

  vec_t       vecs[6];
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  bcd_digit_serializer #(.DIGIT(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_bcd(in_bcd4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_digit(out_digit4),
    .out_last(out_last4), .out_err(out_err4)
  );

  bcd_digit_serializer #(.DIGIT(2)) u2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_bcd(in_bcd2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_digit(out_digit2),
    .out_last(out_last2), .out_err(out_err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset4(input string nm);
    chk({nm, " u4 valid"}, 32'(out_valid4), 32'd0);
    chk({nm, " u4 digit"}, 32'(out_digit4), 32'd0);
    chk({nm, " u4 last"},  32'(out_last4),  32'd0);
    chk({nm, " u4 err"},   32'(out_err4),   32'd0);
    chk({nm, " u4 ready"}, 32'(in_ready4),  32'd1);
  endtask

  task automatic chk_reset2(input string nm);
    chk({nm, " u2 valid"}, 32'(out_valid2), 32'd0);
    chk({nm, " u2 digit"}, 32'(out_digit2), 32'd0);
    chk({nm, " u2 last"},  32'(out_last2),  32'd0);
    chk({nm, " u2 err"},   32'(out_err2),   32'd0);
    chk({nm, " u2 ready"}, 32'(in_ready2),  32'd1);
  endtask

  // Sends one word to u4 with out_ready held high and checks every beat.
  task automatic run_vec(input vec_t v, input string nm);
    logic [15:0] sh;
    in_valid4  = 1'b1;
    in_bcd4    = v.word;
    out_ready4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    for (int i = 0; i < v.nbeats; i++) begin
      sh = v.digits >> (4 * (v.nbeats - 1 - i));
      chk({nm, " valid"}, 32'(out_valid4), 32'd1);
      chk({nm, " ready"}, 32'(in_ready4),  32'd0);
      chk({nm, " digit"}, 32'(out_digit4), 32'(sh[3:0]));
      chk({nm, " last"},  32'(out_last4),  32'(i == v.nbeats - 1));
      chk({nm, " err"},   32'(out_err4),   32'(v.errs[v.nbeats - 1 - i]));
      tick();
    end
    chk({nm, " idle valid"}, 32'(out_valid4), 32'd0);
    chk({nm, " idle ready"}, 32'(in_ready4),  32'd1);
  endtask

  // Reference: the digits a word must produce, in emission order.
  task automatic push_word(input logic [15:0] w, input int nd);
    int st;
    st = nd - 1;
`ifdef BCD_LZS_EN
    st = 0;
    for (int k = 0; k < nd; k++) if (w[4*k +: 4] != 4'd0) st = k;
`endif
    for (int k = st; k >= 0; k--) exp_q.push_back(w[4*k +: 4]);
  endtask

  initial begin
`ifdef BCD_LZS_EN
    vecs[0] = '{16'h0907, 3, 16'h0907, 4'b0000};
    vecs[1] = '{16'h0000, 1, 16'h0000, 4'b0000};
    vecs[2] = '{16'h1A23, 4, 16'h1A23, 4'b0100};
    vecs[3] = '{16'h9999, 4, 16'h9999, 4'b0000};
    vecs[4] = '{16'h0005, 1, 16'h0005, 4'b0000};
    vecs[5] = '{16'hF000, 4, 16'hF000, 4'b1000};
`else
    vecs[0] = '{16'h0907, 4, 16'h0907, 4'b0000};
    vecs[1] = '{16'h0000, 4, 16'h0000, 4'b0000};
    vecs[2] = '{16'h1A23, 4, 16'h1A23, 4'b0100};
    vecs[3] = '{16'h9999, 4, 16'h9999, 4'b0000};
    vecs[4] = '{16'h0005, 4, 16'h0005, 4'b0000};
    vecs[5] = '{16'hF000, 4, 16'hF000, 4'b1000};
`endif

    rst = 1'b1;
    in_valid4 = 1'b0; in_bcd4 = 16'h0; out_ready4 = 1'b0;
    in_valid2 = 1'b0; in_bcd2 = 8'h0;  out_ready2 = 1'b0;

    // Reset held for three cycles, then released.
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_reset4("rst hold");
      chk_reset2("rst hold");
      tick();
    end
    rst = 1'b0;
    #1;
    chk_reset4("rst release");
    chk_reset2("rst release");
    tick();
    chk_reset4("post rst");

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure on the 2-digit instance; in_valid pulses during SEND must be ignored.
    in_valid2 = 1'b1; in_bcd2 = 8'h58; out_ready2 = 1'b0;
    tick();
    in_bcd2 = 8'h99;
    for (int i = 0; i < 3; i++) begin
      chk("bp hold valid", 32'(out_valid2), 32'd1);
      chk("bp hold ready", 32'(in_ready2),  32'd0);
      chk("bp hold digit", 32'(out_digit2), 32'd5);
      chk("bp hold last",  32'(out_last2),  32'd0);
      in_valid2 = (i != 1);
      tick();
    end
    out_ready2 = 1'b1;
    in_valid2  = 1'b1;
    chk("bp beat0 digit", 32'(out_digit2), 32'd5);
    chk("bp beat0 last",  32'(out_last2),  32'd0);
    tick();
    chk("bp beat1 valid", 32'(out_valid2), 32'd1);
    chk("bp beat1 digit", 32'(out_digit2), 32'd8);
    chk("bp beat1 last",  32'(out_last2),  32'd1);
    in_valid2 = 1'b0;
    tick();
    chk("bp idle valid", 32'(out_valid2), 32'd0);
    chk("bp idle ready", 32'(in_ready2),  32'd1);

    // Reset asserted mid-word clears outputs immediately; next word starts fresh.
    in_valid4 = 1'b1; in_bcd4 = 16'h4321; out_ready4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    chk("mid beat0 digit", 32'(out_digit4), 32'd4);
    tick();
    chk("mid beat1 digit", 32'(out_digit4), 32'd3);
    rst = 1'b1;
    #1;
    chk_reset4("mid rst async");
    tick();
    rst = 1'b0;
    #1;
    chk_reset4("mid rst release");
    tick();
    chk_reset4("mid rst idle");
`ifdef BCD_LZS_EN
    run_vec('{16'h0055, 2, 16'h0055, 4'b0000}, "after rst");
`else
    run_vec('{16'h0055, 4, 16'h0055, 4'b0000}, "after rst");
`endif

    // Randomized traffic against the digit-queue model.
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      logic        v, iv, ordy;
      logic [15:0] w;
      v = (exp_q.size() > 0);
      chk("rnd valid", 32'(out_valid4), 32'(v));
      chk("rnd ready", 32'(in_ready4),  32'(!v));
      if (v) begin
        chk("rnd digit", 32'(out_digit4), 32'(exp_q[0]));
        chk("rnd last",  32'(out_last4),  32'(exp_q.size() == 1));
        chk("rnd err",   32'(out_err4),   32'(exp_q[0] > 4'd9));
      end
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 2) == 0) w[4*k +: 4] = 4'd0;
        else if ($urandom_range(0, 7) == 0) w[4*k +: 4] = 4'($urandom_range(10, 15));
        else w[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      iv   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      in_valid4  = iv;
      in_bcd4    = w;
      out_ready4 = ordy;
      if (v && ordy) void'(exp_q.pop_front());
      else if (!v && iv) push_word(w, 4);
      tick();
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    repeat (6) tick();
    chk("drain valid", 32'(out_valid4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_digit_serializer.md
# bcd_digit_serializer

Sequential stage directly downstream of the binary-to-BCD converter. It captures a packed multi-digit BCD word through a valid/ready handshake, then emits the word one 4-bit digit per beat, most significant digit first, to a digit-serial consumer such as a display scanner or UART formatter. It tags the last digit of each word and flags any nibble that is not a legal BCD digit.

## Interface
- `DIGIT`, default 2: number of BCD digits per input word; must be ≥ 1.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: `in_bcd` holds a word.
- `in_ready` output, 1 bit: the block accepts a word this cycle.
- `in_bcd` input, DIGIT*4 bits: packed BCD word; digit k is `[4k+3:4k]`, and k = DIGIT-1 is the MSD.
- `out_valid` output, 1 bit: `out_digit` is presented.
- `out_ready` input, 1 bit: the consumer accepts the digit.
- `out_digit` output, 4 bits: current digit.
- `out_last` output, 1 bit: current digit is the final digit of the word (the LSD).
- `out_err` output, 1 bit: current digit value is greater than 9.

## Operation
- The block has two states, IDLE and SEND. Reset puts it in IDLE.
- In IDLE, `in_ready`=1. When `in_valid`&&`in_ready`:
  - register `in_bcd` into the word buffer;
  - load the digit index with DIGIT-1, or with the first-emitted index when the configuration feature is on;
  - go to SEND.
- In SEND, `in_ready`=0 and `out_valid`=1.
  - `out_digit`, `out_last` and `out_err` come from the registered buffer nibble at the current index.
- A digit beat completes when `out_valid`&&`out_ready`.
  - If `out_last`=1, the next state is IDLE.
  - Otherwise the index decrements by 1.
- While `out_valid`=1 and `out_ready`=0, all of `out_digit`, `out_last` and `out_err` hold stable.
- `out_err` = (`out_digit` > 9). The digit is passed through unmodified; an error does not abort the word.
- `in_valid` in SEND is ignored. The upstream word is not consumed and must be held by the producer.
- The index is `$clog2(DIGIT)` bits wide, with a minimum of 1. It never wraps below 0, because the beat at index 0 is always the last beat.
- Reset asserted mid-word:
  - the word is discarded immediately (asynchronously);
  - the state returns to IDLE;
  - no partial continuation after reset is released.

## Timing
- Values while `rst`=1 and after it is released:
  - `out_valid`=0, `out_digit`=0, `out_last`=0, `out_err`=0;
  - the buffer and the index are 0;
  - `in_ready`=1, because it is decoded from the IDLE state.
- Latency: a word accepted at edge N has its first digit presented after edge N, with `out_valid`=1 in cycle N+1.
- With `out_ready` held at 1, one digit is emitted per cycle:
  - a full word occupies DIGIT cycles of `out_valid`;
  - this is followed by one IDLE cycle with `in_ready`=1.
  - Throughput is one word per DIGIT+1 cycles.
- All outputs come directly from registers or from the state decode. There is no combinational path from `out_ready` or `in_valid` to any output.

## Configuration
- `BCD_LZS_EN` defined: leading-zero suppression.
  - At capture, the start index is the highest k whose nibble is non-zero. If every nibble is zero, the start index is 0.
  - Suppressed digits are never presented.
  - At least one digit (the LSD) is always emitted.
  - An illegal nibble (>9) counts as non-zero.
- `BCD_LZS_EN` undefined: every word emits exactly DIGIT digits, starting at index DIGIT-1.

## Test plan
- **Reset values.** Hold `rst`=1 for 3 cycles, then release. Required: all outputs at their reset values throughout; `in_ready`=1.
- **Basic word.** DIGIT=4, `in_bcd`=16'h0907, `out_ready`=1.
  - Without `BCD_LZS_EN`: digits 0, 9, 0, 7 on consecutive cycles; `out_last` high only on the 7; `in_ready` returns to 1 one cycle later.
  - With `BCD_LZS_EN`: digits 9, 0, 7.
- **All-zero word.** DIGIT=4, `in_bcd`=0, with `BCD_LZS_EN` defined. Required: a single beat with digit 0 and `out_last`=1.
- **Back-pressure.** DIGIT=2, `in_bcd`=8'h58; `out_ready`=0 for 3 cycles after `out_valid` rises, then 1. Required: 5 held stable for 3 cycles, then 5 followed by 8 (`out_last`=1 on the 8); `in_valid` pulses during SEND are not accepted.
- **Illegal digit.** DIGIT=4, `in_bcd`=16'h1A23. Required: `out_err`=1 only on the second beat, with digit 4'hA; all four beats are still emitted.
- **Reset mid-word.** Assert `rst` after the first digit of 16'h4321. Required: outputs clear in the same cycle; after release the block is in IDLE, and the next word (16'h0055) is emitted in full from its MSD.
